// File: rtl/regression_pkg.sv
// Shared constants and types for the least-squares regression engine blocks.
package regression_pkg;

   localparam int unsigned N_DEFAULT = 16;
   localparam int unsigned W_DEFAULT = 20;

   typedef enum logic [2:0] {
      FILL,
      ARM,
      LAUNCH,
      RUN,
      DRAIN
   } loader_state_t;

endpackage : regression_pkg

// File: rtl/regression_sample_ram.sv
// N-entry sample buffer: one synchronous write port, one asynchronous read port.
module regression_sample_ram
   import regression_pkg::*;
#(
   parameter int unsigned N  = N_DEFAULT,
   parameter int unsigned DW = 2 * W_DEFAULT,
   parameter int unsigned AW = $clog2(N)
) (
   input  logic          clk,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [DW-1:0] wdata_i,
   input  logic [AW-1:0] raddr_i,
   output logic [DW-1:0] rdata_o
);

   logic [DW-1:0] mem_q [N];

   // Contents are intentionally not reset.
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule : regression_sample_ram

// File: rtl/regression_sample_loader.sv
// Collects N (x, y) pairs, launches a regression run when the controller is idle,
// and serves the stored pairs through a sequential read pointer during the run.
module regression_sample_loader
   import regression_pkg::*;
#(
   parameter int unsigned N  = N_DEFAULT,
   parameter int unsigned W  = W_DEFAULT,
   parameter int unsigned AW = $clog2(N)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   input  logic [W-1:0]  in_x,
   input  logic [W-1:0]  in_y,
   output logic          in_ready,
   input  logic          ctrl_ready,
   output logic          start,
   input  logic          rd_inc,
   input  logic          rd_rewind,
   output logic [W-1:0]  rd_x,
   output logic [W-1:0]  rd_y,
   output logic          rd_last,
   output logic [AW:0]   fill_cnt,
   output logic          done
);

   loader_state_t  state_q, state_d;
   logic [AW:0]    fill_cnt_q, fill_cnt_d;
   logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
   logic           wr_en_c;
   logic           done_c;
   logic [2*W-1:0] rdata_c;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= FILL;
         fill_cnt_q <= '0;
         rd_ptr_q   <= '0;
      end else begin
         state_q    <= state_d;
         fill_cnt_q <= fill_cnt_d;
         rd_ptr_q   <= rd_ptr_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      fill_cnt_d = fill_cnt_q;
      rd_ptr_d   = rd_ptr_q;
      wr_en_c    = 1'b0;
      done_c     = 1'b0;

      unique case (state_q)
         FILL: begin
            if (in_valid) begin
               wr_en_c    = 1'b1;
               fill_cnt_d = fill_cnt_q + (AW+1)'(1);
               if (fill_cnt_q == (AW+1)'(N - 1)) begin
                  state_d = ARM;
               end
            end
         end
         ARM: begin
            if (ctrl_ready) begin
               state_d = LAUNCH;
            end
         end
         LAUNCH: begin
            state_d = RUN;
         end
         RUN: begin
            // Controller dropping idle confirms it has taken the run.
            if (!ctrl_ready) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (ctrl_ready) begin
               done_c     = 1'b1;
               fill_cnt_d = '0;
               state_d    = FILL;
            end
         end
         default: begin
            state_d = FILL;
         end
      endcase

      if (done_c || rd_rewind) begin
         rd_ptr_d = '0;
      end else if (rd_inc) begin
         rd_ptr_d = (rd_ptr_q == AW'(N - 1)) ? '0 : rd_ptr_q + AW'(1);
      end

      // Reset wins over a same-cycle handshake or completion.
      if (rst) begin
         wr_en_c = 1'b0;
         done_c  = 1'b0;
      end
   end

   regression_sample_ram #(
      .N  (N),
      .DW (2 * W),
      .AW (AW)
   ) u_ram (
      .clk     (clk),
      .we_i    (wr_en_c),
      .waddr_i (fill_cnt_q[AW-1:0]),
      .wdata_i ({in_x, in_y}),
      .raddr_i (rd_ptr_q),
      .rdata_o (rdata_c)
   );

   assign in_ready = (state_q == FILL);
   assign start    = (state_q == LAUNCH);
   assign done     = done_c;
   assign fill_cnt = fill_cnt_q;
   assign rd_last  = (rd_ptr_q == AW'(N - 1));
   assign rd_x     = rdata_c[2*W-1:W];
   assign rd_y     = rdata_c[W-1:0];

endmodule : regression_sample_loader

// File: tb/tb_regression_sample_loader.sv
// Bench for regression_sample_loader: directed scenarios plus randomized traffic,
// all outputs compared every cycle against a transaction-level model.
module tb_regression_sample_loader;

   localparam int unsigned N  = 16;
   localparam int unsigned W  = 20;
   localparam int unsigned AW = $clog2(N);

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic [W-1:0]  in_x, in_y;
   logic          in_ready;
   logic          ctrl_ready;
   logic          start;
   logic          rd_inc, rd_rewind;
   logic [W-1:0]  rd_x, rd_y;
   logic          rd_last;
   logic [AW:0]   fill_cnt;
   logic          done;

   int n_cmp = 0;
   int n_bad = 0;
   int n_start = 0;
   bit chk_en = 1'b0;

   // Model: a buffer of N pairs that is either being collected or owned by one run.
   logic [W-1:0] m_x [N];
   logic [W-1:0] m_y [N];
   int m_cnt = 0;
   int m_ptr = 0;
   bit m_full = 0;    // N pairs collected, buffer belongs to the pending/active run
   bit m_start = 0;   // start request visible this cycle
   bit m_issued = 0;  // start already given for this buffer
   bit m_busy = 0;    // controller has been seen busy since start

   logic [W-1:0] sx [N];
   logic [W-1:0] sy [N];

   always #5 clk = ~clk;

   regression_sample_loader #(.N(N), .W(W), .AW(AW)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_x       (in_x),
      .in_y       (in_y),
      .in_ready   (in_ready),
      .ctrl_ready (ctrl_ready),
      .start      (start),
      .rd_inc     (rd_inc),
      .rd_rewind  (rd_rewind),
      .rd_x       (rd_x),
      .rd_y       (rd_y),
      .rd_last    (rd_last),
      .fill_cnt   (fill_cnt),
      .done       (done)
   );

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   always @(posedge clk) begin
      if (rst) begin
         m_cnt = 0; m_ptr = 0; m_full = 0; m_start = 0; m_issued = 0; m_busy = 0;
      end else begin
         bit fin;
         fin = m_full && m_issued && m_busy && ctrl_ready;
         if (!m_full) begin
            if (in_valid) begin
               m_x[m_cnt] = in_x;
               m_y[m_cnt] = in_y;
               m_cnt++;
               if (m_cnt == N) m_full = 1;
            end
         end else if (!m_issued) begin
            if (m_start) begin
               m_start = 0;
               m_issued = 1;
            end else if (ctrl_ready) begin
               m_start = 1;
            end
         end else if (!m_busy) begin
            if (!ctrl_ready) m_busy = 1;
         end else if (ctrl_ready) begin
            m_full = 0; m_issued = 0; m_busy = 0; m_cnt = 0;
         end
         if (fin || rd_rewind) m_ptr = 0;
         else if (rd_inc) m_ptr = (m_ptr + 1) % N;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("in_ready", 32'(in_ready), 32'(!m_full));
         check("start", 32'(start), 32'(m_start));
         check("done", 32'(done), 32'(m_full && m_issued && m_busy && ctrl_ready && !rst));
         check("fill_cnt", 32'(fill_cnt), 32'(m_cnt));
         check("rd_last", 32'(rd_last), 32'(m_ptr == N - 1));
         if (m_full) begin
            check("rd_x", 32'(rd_x), 32'(m_x[m_ptr]));
            check("rd_y", 32'(rd_y), 32'(m_y[m_ptr]));
         end
         if (start === 1'b1) n_start++;
      end
   end

   task automatic send(input logic [W-1:0] x, input logic [W-1:0] y);
      bit hs;
      in_valid = 1'b1; in_x = x; in_y = y;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         hs = in_ready;
         tick();
         if (hs) begin
            in_valid = 1'b0;
            return;
         end
      end
      in_valid = 1'b0;
      check("send_timeout", 32'(0), 32'(1));
   endtask

   task automatic wait_start(output int gap);
      bit found;
      found = 0;
      gap = 0;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         gap++;
         if (start === 1'b1) begin
            found = 1;
            break;
         end
      end
      if (!found) check("start_timeout", 32'(0), 32'(1));
      tick();
   endtask

   task automatic steps(input int n);
      for (int k = 0; k < n; k++) tick();
   endtask

   initial begin
      int gap;
      int s0;
      rst = 1'b1; in_valid = 1'b0; in_x = '0; in_y = '0;
      ctrl_ready = 1'b1; rd_inc = 1'b0; rd_rewind = 1'b0;
      steps(2);
      rst = 1'b0;
      chk_en = 1'b1;
      @(negedge clk);
      check("rst_in_ready", 32'(in_ready), 32'(1));
      check("rst_fill_cnt", 32'(fill_cnt), 32'(0));
      check("rst_start", 32'(start), 32'(0));
      check("rst_rd_last", 32'(rd_last), 32'(0));
      tick();

      // Continuous fill x=i, y=2i+1 with an idle controller.
      s0 = n_start;
      for (int i = 0; i < N; i++) send(W'(i), W'(2 * i + 1));
      @(negedge clk);
      check("full_in_ready", 32'(in_ready), 32'(0));
      check("full_fill_cnt", 32'(fill_cnt), 32'(16));
      tick();
      gap = 1;
      begin
         int g2;
         wait_start(g2);
         gap += g2;
      end
      check("fill_to_start", 32'(gap), 32'(2));
      for (int i = 0; i < N; i++) begin
         @(negedge clk);
         check("seq_rd_x", 32'(rd_x), 32'(i));
         check("seq_rd_y", 32'(rd_y), 32'(2 * i + 1));
         check("seq_rd_last", 32'(rd_last), 32'(i == 15));
         rd_inc = 1'b1;
         tick();
         rd_inc = 1'b0;
      end
      @(negedge clk);
      check("wrap_rd_x", 32'(rd_x), 32'(0));
      tick();
      in_valid = 1'b1; in_x = W'($urandom); in_y = W'($urandom);
      steps(5);
      in_valid = 1'b0;
      ctrl_ready = 1'b0;
      steps(50);
      ctrl_ready = 1'b1;
      @(negedge clk);
      check("done_pulse", 32'(done), 32'(1));
      tick();
      @(negedge clk);
      check("post_done", 32'(done), 32'(0));
      check("post_in_ready", 32'(in_ready), 32'(1));
      check("post_fill_cnt", 32'(fill_cnt), 32'(0));
      check("start_once", 32'(n_start - s0), 32'(1));
      tick();

      // Bubbly fill while the controller is busy; start must wait for idle.
      ctrl_ready = 1'b0;
      for (int i = 0; i < N; i++) begin
         sx[i] = W'($urandom);
         sy[i] = W'($urandom);
         send(sx[i], sy[i]);
         tick();
      end
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         check("arm_hold_start", 32'(start), 32'(0));
         tick();
      end
      ctrl_ready = 1'b1;
      wait_start(gap);
      check("idle_to_start", 32'(gap), 32'(2));
      for (int i = 0; i < N + 9; i++) begin
         @(negedge clk);
         check("bub_rd_x", 32'(rd_x), 32'(sx[i % N]));
         check("bub_rd_y", 32'(rd_y), 32'(sy[i % N]));
         rd_inc = 1'b1;
         tick();
         rd_inc = 1'b0;
      end
      @(negedge clk);
      check("ptr9_rd_x", 32'(rd_x), 32'(sx[9]));
      tick();
      rd_rewind = 1'b1; rd_inc = 1'b1;
      tick();
      rd_rewind = 1'b0; rd_inc = 1'b0;
      @(negedge clk);
      check("rewind_rd_x", 32'(rd_x), 32'(sx[0]));
      check("rewind_rd_y", 32'(rd_y), 32'(sy[0]));
      tick();
      ctrl_ready = 1'b0;
      steps(3);
      ctrl_ready = 1'b1;
      @(negedge clk);
      check("done_pulse2", 32'(done), 32'(1));
      tick();

      // Reset mid-fill and mid-run.
      for (int i = 0; i < 7; i++) send(W'($urandom), W'($urandom));
      rd_inc = 1'b1;
      steps(15);
      rd_inc = 1'b0;
      @(negedge clk);
      check("pre_rst_rd_last", 32'(rd_last), 32'(1));
      rst = 1'b1;
      tick();
      rst = 1'b0;
      @(negedge clk);
      check("rst_fill_cnt7", 32'(fill_cnt), 32'(0));
      check("rst_rd_last7", 32'(rd_last), 32'(0));
      check("rst_in_ready7", 32'(in_ready), 32'(1));
      tick();
      for (int i = 0; i < N; i++) send(W'($urandom), W'($urandom));
      wait_start(gap);
      ctrl_ready = 1'b0;
      rd_inc = 1'b1;
      steps(15);
      rd_inc = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      ctrl_ready = 1'b1;
      @(negedge clk);
      check("run_rst_fill_cnt", 32'(fill_cnt), 32'(0));
      check("run_rst_start", 32'(start), 32'(0));
      check("run_rst_rd_last", 32'(rd_last), 32'(0));
      check("run_rst_in_ready", 32'(in_ready), 32'(1));
      tick();

      // Randomized traffic.
      for (int k = 0; k < 1500; k++) begin
         in_valid  = ($urandom_range(0, 9) < 6);
         in_x      = W'($urandom);
         in_y      = W'($urandom);
         if ($urandom_range(0, 7) == 0) ctrl_ready = ~ctrl_ready;
         rd_inc    = ($urandom_range(0, 1) == 1);
         rd_rewind = ($urandom_range(0, 15) == 0);
         rst       = ($urandom_range(0, 299) == 0);
         tick();
      end
      rst = 1'b0; in_valid = 1'b0; rd_inc = 1'b0; rd_rewind = 1'b0;
      steps(3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule : tb_regression_sample_loader

// File: doc/regression_sample_loader.md
# regression_sample_loader

Upstream front-end for the least-squares regression engine. It accepts a stream of (x, y) sample pairs over a valid/ready handshake and stores exactly N pairs in an internal buffer. It then pulses `start` to the regression controller once that controller reports idle. During the run it serves the stored pairs to the datapath through a sequential read pointer with a last-element flag, and refills only after the run completes.

## Interface
Parameters:
- `N`, 16: samples per run; N ≥ 2.
- `W`, 20: sample width; x and y are unsigned.
- `AW`, $clog2(N): address and count width.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  upstream sample pair valid.
- `in_x`  in  W  sample x.
- `in_y`  in  W  sample y.
- `in_ready`  out  1  loader can accept a pair this cycle.
- `ctrl_ready`  in  1  regression controller idle indication.
- `start`  out  1  one-cycle run request to controller.
- `rd_inc`  in  1  advance read pointer (datapath enable).
- `rd_rewind`  in  1  read pointer to 0 (second pass, error pass).
- `rd_x`  out  W  x at read pointer.
- `rd_y`  out  W  y at read pointer.
- `rd_last`  out  1  read pointer == N-1 (carry-out to controller).
- `fill_cnt`  out  AW+1  pairs stored for the pending run.
- `done`  out  1  one-cycle pulse when a run has finished.

## Operation
- FSM states: FILL, ARM, LAUNCH, RUN, DRAIN.
- FILL
  - `in_ready`=1; each handshake (`in_valid`&&`in_ready`) writes mem[fill_cnt] and increments fill_cnt.
  - The handshake that makes fill_cnt == N goes to ARM.
- ARM
  - `in_ready`=0.
  - If `ctrl_ready`=1, go to LAUNCH; otherwise hold.
- LAUNCH: `start`=1 for exactly this cycle; go to RUN.
- RUN: wait for `ctrl_ready`=0 (controller has left idle), then go to DRAIN.
- DRAIN
  - Wait for `ctrl_ready`=1.
  - On that cycle: `done`=1, fill_cnt←0, read pointer←0, go to FILL.
- Read pointer rd_ptr (AW bits)
  - `rd_rewind` takes priority over `rd_inc` and sets rd_ptr to 0.
  - `rd_inc` increments rd_ptr, wrapping N-1→0.
  - The pointer operates in every state; the buffer contents are guaranteed stable only in ARM, LAUNCH, RUN and DRAIN.
- `rd_x`/`rd_y` = mem[rd_ptr], combinational (asynchronous read).
- `rd_last` = (rd_ptr == N-1), combinational.
- Writes occur only in FILL. The buffer is never written while a run is in progress.

## Timing
- Reset values:
  - State: FILL.
  - fill_cnt=0, rd_ptr=0.
  - `in_ready`=1 (from the cycle after reset), `start`=0, `done`=0, `rd_last`=0.
  - Memory contents are undefined (not reset).
- Reset is synchronous. `rst` asserted in any state, including mid-fill or mid-run, returns to FILL with counters cleared on the next edge, and is dominant over all other inputs.
- `in_ready` and `start` are decoded from registered state (Moore); they do not depend on same-cycle inputs.
- Fill latency: the N-th handshake at edge t puts the FSM in ARM after t. With `ctrl_ready`=1, LAUNCH follows at t+1 and `start` is high during the cycle after t+1.
- Minimum gap from last accepted sample to `start` high: 2 cycles.
- `done` is high for exactly one cycle. `in_ready` rises in the cycle following `done`.
- If `ctrl_ready` is already 0 in ARM, the FSM waits in ARM; `start` is never issued while the controller is busy.
- If the controller keeps `ctrl_ready`=1 after `start`, the FSM stays in RUN and no second `start` is issued.
- Simultaneous `rd_rewind`+`rd_inc`: rd_ptr←0.
- `rd_inc` at rd_ptr=N-1 wraps to 0.
- `in_valid` outside FILL is ignored: no write, no count change.

## Structure
- Shared package `regression_pkg`:
  - State enum `loader_state_t` {FILL, ARM, LAUNCH, RUN, DRAIN}.
  - Default `N`/`W` constants, shared with the controller and datapath.
- One sub-module, `regression_sample_ram`: N×(2W) array with synchronous write and asynchronous read, one write port and one read port.
- The FSM, fill counter and read pointer stay in the top module.

## Test plan
- Reset, then 16 pairs (x=i, y=2i+1) with continuous `in_valid`, `ctrl_ready`=1:
  - `in_ready` falls after the 16th handshake.
  - `start` pulses exactly once, 2 cycles later.
  - fill_cnt=16.
- During RUN, 16 `rd_inc` pulses:
  - `rd_x`/`rd_y` read back 0/1, 1/3, …, 15/31.
  - `rd_last`=1 only at index 15.
  - The pointer wraps to 0.
- Full buffer with `ctrl_ready`=0 for 10 cycles: FSM holds in ARM and `start` stays 0; `ctrl_ready`→1 gives `start` 2 cycles later.
- After `start`, `ctrl_ready` low for 50 cycles then high:
  - `done` pulses for one cycle.
  - `in_ready`=1 the next cycle, fill_cnt=0.
  - Extra `in_valid` during RUN causes no writes.
- `rst` asserted after 7 pairs, and again mid-RUN: next cycle state is FILL, fill_cnt=0, rd_ptr=0, `start`=0.
- `rd_rewind`+`rd_inc` together at rd_ptr=9: rd_ptr=0; bubbly `in_valid` (alternating 0/1) still stores all 16 pairs in order.
